// File: rtl/axil_uart_reg_arbiter_if.sv
// AXI4-Lite bus between the requester arbiter (master) and the UART S00_AXI
// register slave.
interface axil_uart_reg_arbiter_if #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [2:0]                m_axi_awprot;
    logic                      m_axi_awvalid;
    logic                      m_axi_awready;
    logic [C_DATA_WIDTH-1:0]   m_axi_wdata;
    logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                      m_axi_wvalid;
    logic                      m_axi_wready;
    logic [1:0]                m_axi_bresp;
    logic                      m_axi_bvalid;
    logic                      m_axi_bready;
    logic [C_ADDR_WIDTH-1:0]   m_axi_araddr;
    logic [2:0]                m_axi_arprot;
    logic                      m_axi_arvalid;
    logic                      m_axi_arready;
    logic [C_DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axil_uart_reg_arbiter.sv
// Round-robin two-requester arbiter sequencing single AXI4-Lite transfers to
// the UART register slave. Optional watchdog enabled by `define ARB_TIMEOUT_EN.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for req, grants one requester per edge
//   S_WR    | awvalid/wvalid asserted, handshakes tracked independently
//   S_WR_B  | bready asserted, waiting for write response
//   S_RD_AR | arvalid asserted, waiting for arready
//   S_RD_R  | rready asserted, waiting for read data
//   S_DONE  | one-cycle ack to the granted requester
module axil_uart_reg_arbiter #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_TIMEOUT    = 255
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [1:0]                req,
    input  logic [1:0]                we,
    input  logic [2*C_ADDR_WIDTH-1:0] addr,
    input  logic [2*C_DATA_WIDTH-1:0] wdata,
    output logic [1:0]                ack,
    output logic [C_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                resp,
    axil_uart_reg_arbiter_if.master   m_axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD_AR,
        S_RD_R,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic                    sel;
    logic                    grant;
    logic                    last_grant;
    logic                    aw_done;
    logic                    w_done;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    in_wait;
    logic                    timeout;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_DATA_WIDTH-1:0] wdata_q;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        sel = 1'b0;
        if (req == 2'b11) sel = ~last_grant;
        else              sel = req[1];
    end

    assign aw_hs   = m_axi.m_axi_awvalid & m_axi.m_axi_awready;
    assign w_hs    = m_axi.m_axi_wvalid  & m_axi.m_axi_wready;
    assign in_wait = (state == S_WR) || (state == S_WR_B) ||
                     (state == S_RD_AR) || (state == S_RD_R);

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (C_TIMEOUT < 2) ? 1 : $clog2(C_TIMEOUT);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)      to_cnt <= '0;
        else if (!in_wait) to_cnt <= '0;
        else               to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = in_wait && (to_cnt == TW'(C_TIMEOUT - 1));
`else
    // Watchdog compiled out: the sequencer waits on the slave indefinitely.
    assign timeout = (C_TIMEOUT < 0);
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req != 2'b00) state_nx = we[sel] ? S_WR : S_RD_AR;
            end
            S_WR: begin
                if (timeout)                                  state_nx = S_DONE;
                else if ((aw_done | aw_hs) && (w_done | w_hs)) state_nx = S_WR_B;
            end
            S_WR_B: begin
                if (timeout || m_axi.m_axi_bvalid) state_nx = S_DONE;
            end
            S_RD_AR: begin
                if (timeout)                   state_nx = S_DONE;
                else if (m_axi.m_axi_arready)  state_nx = S_RD_R;
            end
            S_RD_R: begin
                if (timeout || m_axi.m_axi_rvalid) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata      <= '0;
            resp       <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        grant      <= sel;
                        last_grant <= sel;
                        addr_q     <= sel ? addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH]
                                          : addr[C_ADDR_WIDTH-1:0];
                        wdata_q    <= sel ? wdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH]
                                          : wdata[C_DATA_WIDTH-1:0];
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                    end
                end
                S_WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                S_WR_B: begin
                    if (m_axi.m_axi_bvalid) begin
                        resp  <= m_axi.m_axi_bresp;
                        rdata <= '0;
                    end
                end
                S_RD_R: begin
                    if (m_axi.m_axi_rvalid) begin
                        resp  <= m_axi.m_axi_rresp;
                        rdata <= m_axi.m_axi_rdata;
                    end
                end
                default: ;
            endcase
            // Watchdog expiry overrides any response arriving in the same cycle.
            if (timeout) begin
                resp  <= 2'b10;
                rdata <= '0;
            end
        end
    end

    assign m_axi.m_axi_awaddr  = addr_q;
    assign m_axi.m_axi_araddr  = addr_q;
    assign m_axi.m_axi_wdata   = wdata_q;
    assign m_axi.m_axi_awprot  = 3'b000;
    assign m_axi.m_axi_arprot  = 3'b000;
    assign m_axi.m_axi_wstrb   = '1;
    assign m_axi.m_axi_awvalid = (state == S_WR) && !aw_done;
    assign m_axi.m_axi_wvalid  = (state == S_WR) && !w_done;
    assign m_axi.m_axi_bready  = (state == S_WR_B);
    assign m_axi.m_axi_arvalid = (state == S_RD_AR);
    assign m_axi.m_axi_rready  = (state == S_RD_R);
    assign ack = (state == S_DONE) ? (grant ? 2'b10 : 2'b01) : 2'b00;

endmodule
